key_debounce_sync: RTL

//  Front end for the board push-buttons. Conditions raw asynchronous KEY pins before

---
 rtl/finalproject_pkg.sv | 15 +
 rtl/key_debounce_chan.sv | 86 ++++++++
 rtl/key_debounce_sync.sv | 38 +++
 3 files changed

// File: rtl/finalproject_pkg.sv
// Shared constants for the final-project key front end.
// The debounce window is derived from the board clock and the intended settle time.
package finalproject_pkg;

    localparam int CLK_HZ               = 50_000_000;
    localparam int DEBOUNCE_MS          = 10;
    localparam int DEBOUNCE_CYCLES_DEF  = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int KEY_ACTIVE_LOW       = 1;

    // Width needed for a counter that can hold 0..cycles.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One push-button channel: synchronizer, run-length debounce, polarity fix,
// press/release pulses and a sticky press flag.
module key_debounce_chan
    import finalproject_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = KEY_ACTIVE_LOW
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    input  logic sticky_clr,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_sticky
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          INACTIVE = (ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_next;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   r_sticky;
    logic                   w_logical;
    logic                   w_flip;

    // Sync flops come out of reset at the idle pin level so nothing looks pressed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= {SYNC_STAGES{INACTIVE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], key_raw};
        end
    end

    assign w_logical = r_sync[SYNC_STAGES-1] ^ INACTIVE;

    // Any sample agreeing with the current level restarts the run from zero.
    always_comb begin
        w_flip     = 1'b0;
        w_cnt_next = '0;
        if (w_logical != r_level) begin
            if (r_cnt == CNT_MAX) begin
                w_flip = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_sticky  <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_press   <= w_flip & ~r_level;
            r_release <= w_flip & r_level;
            if (w_flip) begin
                r_level <= ~r_level;
            end
            // A press arriving with a clear must not be lost, so set has priority.
            if (r_press) begin
                r_sticky <= 1'b1;
            end else if (sticky_clr) begin
                r_sticky <= 1'b0;
            end
        end
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_sticky  = r_sticky;

endmodule

// File: rtl/key_debounce_sync.sv
// Conditions the raw board KEY pins for the Nios PIO inputs.
// Each key gets its own fully independent channel.
module key_debounce_sync
    import finalproject_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = KEY_ACTIVE_LOW
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic [NUM_KEYS-1:0] sticky_clr,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_sticky
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : gen_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_raw     (key_raw[i]),
            .sticky_clr  (sticky_clr[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_sticky  (key_sticky[i])
        );
    end

endmodule
